// File: rtl/music_player.sv
// Multi-voice square-wave music player: walks a song ROM one note word per step,
// with per-voice tone dividers, articulation gap, pause, stop and looping.
module music_player #(
  parameter int NUM_VOICES = 2,
  parameter int ADDR_W     = 8,
  parameter int STEP_W     = 22
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    play,
  input  logic                    stop,
  input  logic                    loop_en,
  output logic [ADDR_W-1:0]       rom_addr,
  input  logic [8*NUM_VOICES-1:0] rom_data,
  output logic [NUM_VOICES-1:0]   speaker,
  output logic                    playing,
  output logic                    song_done
);

  typedef enum logic [2:0] {IDLE, FETCH, WAIT, PLAY, DONE} state_t;

  localparam logic [STEP_W-1:0] STEP_LAST = '1;
  localparam logic [STEP_W-1:0] GAP_LEN   = {{(STEP_W-1){1'b0}}, 1'b1} << (STEP_W - 4);

  state_t              state, state_next;
  logic [ADDR_W-1:0]   addr_next;
  logic [STEP_W-1:0]   step_cnt;
  logic [5:0]          code       [NUM_VOICES];
  logic [8:0]          note_cnt   [NUM_VOICES];
  logic [7:0]          oct_cnt    [NUM_VOICES];
  logic [2:0]          octave     [NUM_VOICES];
  logic [3:0]          note       [NUM_VOICES];
  logic [8:0]          presc      [NUM_VOICES];
  logic [7:0]          oct_reload [NUM_VOICES];
  logic [NUM_VOICES-1:0] tone, voice_on, edge_hit;
  logic                end_marker, run, in_gap, step_end, load;

  function automatic logic [8:0] prescale(input logic [3:0] n);
    case (n)
      4'd0:    return 9'd511;
      4'd1:    return 9'd482;
      4'd2:    return 9'd455;
      4'd3:    return 9'd430;
      4'd4:    return 9'd405;
      4'd5:    return 9'd383;
      4'd6:    return 9'd361;
      4'd7:    return 9'd341;
      4'd8:    return 9'd322;
      4'd9:    return 9'd303;
      4'd10:   return 9'd286;
      default: return 9'd270;
    endcase
  endfunction

  assign end_marker = (rom_data[7:0] == 8'hFF);
  assign run        = (state == PLAY) && play;
  assign in_gap     = (step_cnt < GAP_LEN);
  assign step_end   = (step_cnt == STEP_LAST);
  assign load       = (state == WAIT) && !stop && !end_marker;
  assign speaker    = tone & voice_on & {NUM_VOICES{run && !in_gap}};

  // Pitch decode: code splits into octave and semitone; octave shortens the second divider.
  always_comb begin
    for (int v = 0; v < NUM_VOICES; v++) begin
      octave[v]     = 3'(code[v] / 6'd12);
      note[v]       = 4'(code[v] % 6'd12);
      presc[v]      = prescale(note[v]);
      oct_reload[v] = 8'hFF >> octave[v];
      voice_on[v]   = (code[v] != 6'd0);
      edge_hit[v]   = (note_cnt[v] == 9'd0) && (oct_cnt[v] == 8'd0);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      rom_addr <= '0;
    end else begin
      state    <= state_next;
      rom_addr <= addr_next;
    end
  end

  // Stop always wins; the end marker either rewinds (looping) or finishes the song.
  always_comb begin
    state_next = state;
    addr_next  = rom_addr;
    playing    = (state == FETCH) || (state == WAIT) || (state == PLAY);
    song_done  = (state == DONE) && !stop;
    if (stop) begin
      state_next = IDLE;
      addr_next  = '0;
    end else begin
      case (state)
        IDLE: begin
          addr_next = '0;
          if (play) state_next = FETCH;
        end
        FETCH: state_next = WAIT;
        WAIT: begin
          if (!end_marker) begin
            state_next = PLAY;
          end else if (loop_en) begin
            addr_next  = '0;
            state_next = FETCH;
          end else begin
            state_next = DONE;
          end
        end
        PLAY: begin
          if (play && step_end) begin
            addr_next  = rom_addr + 1'b1;
            state_next = FETCH;
          end
        end
        DONE: begin
          addr_next  = '0;
          state_next = IDLE;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // Counters start at zero on each note load so every voice begins in phase.
  always_ff @(posedge clk) begin
    if (reset) begin
      step_cnt <= '0;
      tone     <= '0;
      for (int v = 0; v < NUM_VOICES; v++) begin
        code[v]     <= '0;
        note_cnt[v] <= '0;
        oct_cnt[v]  <= '0;
      end
    end else if (load) begin
      step_cnt <= '0;
      tone     <= '0;
      for (int v = 0; v < NUM_VOICES; v++) begin
        code[v]     <= rom_data[8*v +: 6];
        note_cnt[v] <= '0;
        oct_cnt[v]  <= '0;
      end
    end else if (run) begin
      step_cnt <= step_cnt + 1'b1;
      for (int v = 0; v < NUM_VOICES; v++) begin
        note_cnt[v] <= (note_cnt[v] == 9'd0) ? presc[v] : note_cnt[v] - 1'b1;
        if (note_cnt[v] == 9'd0)
          oct_cnt[v] <= (oct_cnt[v] == 8'd0) ? oct_reload[v] : oct_cnt[v] - 1'b1;
        if (edge_hit[v] && voice_on[v] && !in_gap)
          tone[v] <= ~tone[v];
      end
    end
  end

endmodule

// File: tb/tb_music_player.sv
// Bench for music_player: control instance (STEP_W=8) driven by a vector table and
// hand sequences, tone instance (STEP_W=13) driven randomly against a timeline model.
module tb_music_player;

  localparam int T_STEP_W = 13;
  localparam int T_STEPS  = 1 << T_STEP_W;
  localparam int T_GAP    = 1 << (T_STEP_W - 4);

  logic clk;
  int   n_checks = 0;
  int   n_errors = 0;

  // control instance
  logic        c_reset, c_play, c_stop, c_loop;
  logic [1:0]  c_addr;
  logic [15:0] c_data;
  logic [1:0]  c_spk;
  logic        c_playing, c_done;
  logic [15:0] rom_ctl [4];

  // tone instance
  logic        t_reset, t_play, t_stop, t_loop;
  logic [1:0]  t_addr;
  logic [15:0] t_data;
  logic [1:0]  t_spk;
  logic        t_playing, t_done;
  logic [15:0] rom_t [4];

  music_player #(.NUM_VOICES(2), .ADDR_W(2), .STEP_W(8)) u_ctl (
    .clk(clk), .reset(c_reset), .play(c_play), .stop(c_stop), .loop_en(c_loop),
    .rom_addr(c_addr), .rom_data(c_data), .speaker(c_spk),
    .playing(c_playing), .song_done(c_done));

  music_player #(.NUM_VOICES(2), .ADDR_W(2), .STEP_W(T_STEP_W)) u_tone (
    .clk(clk), .reset(t_reset), .play(t_play), .stop(t_stop), .loop_en(t_loop),
    .rom_addr(t_addr), .rom_data(t_data), .speaker(t_spk),
    .playing(t_playing), .song_done(t_done));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Song ROMs answer one clock after the address.
  always @(posedge clk) begin
    c_data <= rom_ctl[c_addr];
    t_data <= rom_t[t_addr];
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // ---------------- control table ----------------
  typedef struct {
    logic       rst, ply, stp;
    int         exp_addr;
    logic       exp_playing, exp_done;
    logic [1:0] exp_spk;
  } vec_t;

  vec_t vecs[12];

  task automatic applyStimulus(input vec_t v, input int idx);
    @(negedge clk);
    c_reset = v.rst; c_play = v.ply; c_stop = v.stp;
    #1;
    checkOutput($sformatf("vec%0d_addr", idx), 32'(c_addr), 32'(v.exp_addr));
    checkOutput($sformatf("vec%0d_playing", idx), 32'(c_playing), 32'(v.exp_playing));
    checkOutput($sformatf("vec%0d_done", idx), 32'(c_done), 32'(v.exp_done));
    checkOutput($sformatf("vec%0d_spk", idx), 32'(c_spk), 32'(v.exp_spk));
  endtask

  // ---------------- control sequences ----------------
  logic [1:0] addr_log [1100];
  logic       done_log [1100];
  logic       play_log [1100];
  logic [1:0] spk_log  [1100];

  // Cycle 0 starts in IDLE; play is held high except during the pause window.
  task automatic runSequence(input int n, input int p_start, input int p_len,
                             input int stop_at, input int rst_at);
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      c_play  = !(c >= p_start && c < p_start + p_len);
      c_stop  = (c == stop_at);
      c_reset = (c == rst_at);
      #1;
      addr_log[c] = c_addr;
      done_log[c] = c_done;
      play_log[c] = c_playing;
      spk_log[c]  = c_spk;
    end
    @(negedge clk);
    c_play = 1'b0; c_stop = 1'b1; c_reset = 1'b0;
    @(negedge clk);
    c_stop = 1'b0;
  endtask

  function automatic int countDone(input int n);
    int s = 0;
    for (int c = 0; c < n; c++) s += int'(done_log[c]);
    return s;
  endfunction

  function automatic int spkOr(input int from, input int to);
    int s = 0;
    for (int c = from; c < to; c++) s |= int'(spk_log[c]);
    return s;
  endfunction

  // ---------------- tone reference model ----------------
  int presc_tab[12] = '{511, 482, 455, 430, 405, 383, 361, 341, 322, 303, 286, 270};
  int m_ph;           // 0 idle, 1 fetch, 2 wait, 3 play, 4 done
  int m_addr, m_a;
  int m_code[2];
  bit m_tog[2];

  function automatic int halfPeriod(input int code);
    return (presc_tab[code % 12] + 1) * (256 >> (code / 12));
  endfunction

  task automatic modelStep();
    logic [15:0] w;
    if (t_reset) begin
      m_ph = 0; m_addr = 0; m_a = 0;
      for (int v = 0; v < 2; v++) begin m_code[v] = 0; m_tog[v] = 0; end
    end else if (t_stop) begin
      m_ph = 0; m_addr = 0;
    end else begin
      case (m_ph)
        0: begin m_addr = 0; if (t_play) m_ph = 1; end
        1: m_ph = 2;
        2: begin
          w = rom_t[m_addr];
          if (w[7:0] == 8'hFF) begin
            if (t_loop) begin m_addr = 0; m_ph = 1; end
            else m_ph = 4;
          end else begin
            m_code[0] = int'(w[5:0]);
            m_code[1] = int'(w[13:8]);
            m_tog[0] = 0; m_tog[1] = 0; m_a = 0; m_ph = 3;
          end
        end
        3: if (t_play) begin
          for (int v = 0; v < 2; v++)
            if (m_code[v] != 0 && m_a >= T_GAP && (m_a % halfPeriod(m_code[v])) == 0)
              m_tog[v] = !m_tog[v];
          if (m_a == T_STEPS - 1) begin m_addr = (m_addr + 1) % 4; m_ph = 1; end
          m_a++;
        end
        default: begin m_addr = 0; m_ph = 0; end
      endcase
    end
  endtask

  function automatic logic [7:0] randVoice(input bit is_byte0);
    logic [5:0] code;
    logic [1:0] top;
    case ($urandom_range(0, 3))
      0:       code = 6'd0;
      1:       code = 6'($urandom_range(1, 63));
      default: code = 6'($urandom_range(48, 63));
    endcase
    top = 2'($urandom_range(0, 3));
    if (is_byte0 && code == 6'd63 && top == 2'b11) top = 2'b01;
    return {top, code};
  endfunction

  initial begin
    int pause_left;
    logic [1:0] exp_spk;

    c_reset = 1'b1; c_play = 1'b0; c_stop = 1'b0; c_loop = 1'b0;
    t_reset = 1'b1; t_play = 1'b0; t_stop = 1'b0; t_loop = 1'b1;
    rom_ctl[0] = 16'h000D; rom_ctl[1] = 16'h0014; rom_ctl[2] = 16'h00FF; rom_ctl[3] = 16'h0005;

    vecs[0]  = '{1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b0, 2'b00};
    vecs[1]  = '{1'b1, 1'b1, 1'b0, 0, 1'b0, 1'b0, 2'b00};
    vecs[2]  = '{1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 2'b00};
    vecs[3]  = '{1'b0, 1'b1, 1'b0, 0, 1'b0, 1'b0, 2'b00};
    vecs[4]  = '{1'b0, 1'b1, 1'b0, 0, 1'b1, 1'b0, 2'b00};
    vecs[5]  = '{1'b0, 1'b1, 1'b0, 0, 1'b1, 1'b0, 2'b00};
    vecs[6]  = '{1'b0, 1'b1, 1'b0, 0, 1'b1, 1'b0, 2'b00};
    vecs[7]  = '{1'b0, 1'b1, 1'b1, 0, 1'b1, 1'b0, 2'b00};
    vecs[8]  = '{1'b0, 1'b1, 1'b0, 0, 1'b0, 1'b0, 2'b00};
    vecs[9]  = '{1'b1, 1'b1, 1'b1, 0, 1'b1, 1'b0, 2'b00};
    vecs[10] = '{1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 2'b00};
    vecs[11] = '{1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 2'b00};

    repeat (2) @(posedge clk);
    for (int i = 0; i < 12; i++) applyStimulus(vecs[i], i);

    // Song end without loop: fetches at 0,1,2 then a single done pulse.
    $display("[TB] sequence: song end, no loop");
    runSequence(521, 9999, 0, -1, -1);
    checkOutput("end_addr0", 32'(addr_log[1]), 0);
    checkOutput("end_play_at_pl", 32'(play_log[3]), 1);
    checkOutput("end_addr_before_step", 32'(addr_log[258]), 0);
    checkOutput("end_addr1", 32'(addr_log[259]), 1);
    checkOutput("end_addr2", 32'(addr_log[517]), 2);
    checkOutput("end_done_pulse", 32'(done_log[519]), 1);
    checkOutput("end_done_count", 32'(countDone(521)), 1);
    checkOutput("end_idle_playing", 32'(play_log[520]), 0);
    checkOutput("end_idle_addr", 32'(addr_log[520]), 0);
    checkOutput("end_gap_spk", 32'(spkOr(3, 19)), 0);
    checkOutput("end_spk_all", 32'(spkOr(0, 521)), 0);

    // Looping: marker rewinds to 0 and keeps playing.
    $display("[TB] sequence: song end, loop");
    c_loop = 1'b1;
    runSequence(790, 9999, 0, -1, -1);
    checkOutput("loop_addr2", 32'(addr_log[517]), 2);
    checkOutput("loop_addr_rewind", 32'(addr_log[519]), 0);
    checkOutput("loop_playing", 32'(play_log[519]), 1);
    checkOutput("loop_addr1_again", 32'(addr_log[777]), 1);
    checkOutput("loop_done_count", 32'(countDone(790)), 0);
    c_loop = 1'b0;

    // Pause 50 clocks into the first step for 100 clocks: step ends 100 late.
    $display("[TB] sequence: pause");
    runSequence(362, 53, 100, -1, -1);
    checkOutput("pause_playing", 32'(play_log[100]), 1);
    checkOutput("pause_addr_held", 32'(addr_log[358]), 0);
    checkOutput("pause_addr_late", 32'(addr_log[359]), 1);
    checkOutput("pause_spk", 32'(spkOr(53, 153)), 0);

    // Stop together with play during the second note.
    $display("[TB] sequence: stop mid-play");
    runSequence(310, 9999, 0, 300, -1);
    checkOutput("stop_addr_before", 32'(addr_log[299]), 1);
    checkOutput("stop_addr", 32'(addr_log[301]), 0);
    checkOutput("stop_playing", 32'(play_log[301]), 0);
    checkOutput("stop_spk", 32'(spk_log[301]), 0);
    checkOutput("stop_done_count", 32'(countDone(310)), 0);

    // Reset in the middle of the second note.
    $display("[TB] sequence: reset mid-play");
    runSequence(310, 9999, 0, -1, 300);
    checkOutput("rst_addr_before", 32'(addr_log[299]), 1);
    checkOutput("rst_addr", 32'(addr_log[301]), 0);
    checkOutput("rst_playing", 32'(play_log[301]), 0);
    checkOutput("rst_restart", 32'(play_log[302]), 1);
    checkOutput("rst_done_count", 32'(countDone(310)), 0);

    // No marker: the address wraps past 3 back to 0.
    $display("[TB] sequence: address wrap");
    rom_ctl[2] = 16'h0007;
    runSequence(1040, 9999, 0, -1, -1);
    checkOutput("wrap_addr3", 32'(addr_log[775]), 3);
    checkOutput("wrap_addr0", 32'(addr_log[1033]), 0);
    checkOutput("wrap_playing", 32'(play_log[1033]), 1);
    checkOutput("wrap_done_count", 32'(countDone(1040)), 0);

    // Randomized tone run against the timeline model.
    $display("[TB] sequence: random tones");
    for (int i = 0; i < 3; i++) rom_t[i] = {randVoice(1'b0), randVoice(1'b1)};
    rom_t[3] = {randVoice(1'b0), 8'hFF};
    @(negedge clk); t_reset = 1'b1;
    @(posedge clk); modelStep();
    @(negedge clk); t_reset = 1'b0;
    @(posedge clk); modelStep();
    pause_left = 0;
    for (int c = 0; c < 50000; c++) begin
      @(negedge clk);
      if (pause_left > 0) begin
        t_play = 1'b0;
        pause_left--;
      end else begin
        t_play = 1'b1;
        if ($urandom_range(0, 1999) == 0) pause_left = $urandom_range(1, 300);
      end
      #1;
      for (int v = 0; v < 2; v++)
        exp_spk[v] = m_tog[v] && m_ph == 3 && t_play && m_a >= T_GAP && m_code[v] != 0;
      checkOutput("tone_spk", 32'(t_spk), 32'(exp_spk));
      checkOutput("tone_addr", 32'(t_addr), 32'(m_addr));
      checkOutput("tone_playing", 32'(t_playing), 32'(m_ph >= 1 && m_ph <= 3));
      checkOutput("tone_done", 32'(t_done), 0);
      @(posedge clk);
      modelStep();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/music_player.md
MUSIC_PLAYER -- requirements
Module: music_player

Interface
REQ-001 SHALL have parameter NUM_VOICES, default 2, meaning number of simultaneous tone voices (legal 1..4).
REQ-002 SHALL have parameter ADDR_W, default 8, meaning song ROM address width.
REQ-003 SHALL have parameter STEP_W, default 22, meaning log2 of clocks per note step (legal 6..30).
REQ-004 SHALL have port clk  input  1  system clock, all logic on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port play  input  1  level; 1 = run or resume, 0 = pause.
REQ-007 SHALL have port stop  input  1  single-cycle abort-and-rewind request.
REQ-008 SHALL have port loop_en  input  1  1 = restart song at end marker.
REQ-009 SHALL have port rom_addr  output  ADDR_W  song ROM read address.
REQ-010 SHALL have port rom_data  input  8*NUM_VOICES  ROM word; byte v drives voice v; valid one clock after rom_addr.
REQ-011 SHALL have port speaker  output  NUM_VOICES  per-voice square-wave output.
REQ-012 SHALL have port playing  output  1  high in FETCH, WAIT, PLAY states.
REQ-013 SHALL have port song_done  output  1  one-cycle pulse at non-looping song end.

Function
REQ-014 SHALL implement states IDLE, FETCH, WAIT, PLAY, DONE.
REQ-015 IDLE: rom_addr held at 0, speaker 0; play=1 and stop=0 -> FETCH.
REQ-016 FETCH: rom_addr presented for one cycle -> WAIT.
REQ-017 WAIT: latch rom_data into per-voice note registers; clear step counter and all tone counters to 0 -> PLAY, unless byte 0 == 8'hFF (end marker).
REQ-018 End marker with loop_en=1: rom_addr <= 0 -> FETCH; with loop_en=0 -> DONE; note registers unchanged.
REQ-019 DONE: song_done=1 for exactly that cycle, rom_addr <= 0 -> IDLE.
REQ-020 PLAY: step counter (STEP_W bits) increments each clock while play=1; on reaching all-ones, rom_addr <= rom_addr+1 (wraps to 0 past max) -> FETCH.
REQ-021 Step period SHALL be 2^STEP_W clocks in PLAY plus 2 clocks FETCH/WAIT.
REQ-022 Gap: while step counter < 2^(STEP_W-4), all speakers SHALL be 0 (note articulation).
REQ-023 Pause: play=0 in PLAY holds step and tone counters, forces speaker 0, state stays PLAY; play=0 in FETCH/WAIT completes to PLAY then holds.
REQ-024 stop=1 in any state SHALL go to IDLE next cycle, rom_addr 0, speaker 0, no song_done; stop wins over play.
REQ-025 Note code = voice byte bits [5:0]; bits [7:6] ignored except end-marker test on byte 0; code 0 = rest (voice silent).
REQ-026 octave = code/12 (0..5), note = code%12, combinational from latched code.
REQ-027 Prescaler by note 0..11: 511,482,455,430,405,383,361,341,322,303,286,270.
REQ-028 Per voice, note counter (9 bits): at 0 reload prescaler, else decrement, every clock in PLAY with play=1.
REQ-029 Per voice, octave counter (8 bits): on note counter 0, at 0 reload 255>>octave, else decrement.
REQ-030 Voice speaker SHALL toggle when both its counters are 0, code nonzero, outside gap, play=1; otherwise holds, except forced 0 per REQ-022/023/024/025.
REQ-031 First toggle after note load SHALL occur on first PLAY cycle (counters start at 0); subsequent half period = (prescaler+1)*((255>>octave)+1) clocks.
REQ-032 Voices SHALL be independent; rest on one voice does not affect others.

Reset
REQ-033 reset=1 SHALL force IDLE, rom_addr 0, speaker 0, playing 0, song_done 0, all counters and note registers 0; reset dominates stop/play.
REQ-034 reset asserted mid-PLAY SHALL take effect next clock with no song_done.

Verification (STEP_W=8, NUM_VOICES=2, 1-cycle ROM model)
REQ-035 Reset, play=1, ROM[0]={8'd0,8'd13} -> rom_addr 0, PLAY after 2 clocks, speaker[0] 0 for first 16 PLAY clocks, speaker[1] always 0.
REQ-036 ROM[0] voice0 code 1 with STEP_W=20 -> speaker[0] half period 483*256=123648 clocks after gap.
REQ-037 ROM = {notes at 0,1; 8'hFF at 2}, loop_en=0 -> rom_addr 0,1,2, song_done single pulse, IDLE, playing 0.
REQ-038 Same ROM, loop_en=1 -> rom_addr sequence 0,1,2,0,1, no song_done.
REQ-039 play dropped 50 clocks into PLAY for 100 clocks -> speaker 0, step count frozen, step ends 100 clocks late.
REQ-040 stop and play both high mid-PLAY -> IDLE next clock, rom_addr 0, speaker 0; reset mid-PLAY likewise.
